// File: rtl/rf_muldiv_unit.sv
// Iterative multiply/divide unit that sits beside reg_file: one shift-add or
// restoring shift-subtract step per cycle, then sign fix-up and a single write-back.
module rf_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sgn,
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    WA,
  output logic [WIDTH-1:0] WD,
  output logic             WE
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, WB} state_t;

  state_t             state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   a_mag_reg, b_mag_reg, a_raw_reg;
  logic               sa_reg, sb_reg;
  logic [1:0]         op_reg;
  logic [AW-1:0]      rd_reg;
  logic               busy_reg, done_reg, we_reg;
  logic [AW-1:0]      wa_reg;
  logic [WIDTH-1:0]   wd_reg;

  logic               sa_in, sb_in;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH-1:0]   quo, rem, result;
  logic               b_zero;

  assign sa_in    = sgn & RD1[WIDTH-1];
  assign sb_in    = sgn & RD2[WIDTH-1];
  assign a_mag_in = sa_in ? -RD1 : RD1;
  assign b_mag_in = sb_in ? -RD2 : RD2;

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV/REM
  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, a_mag_reg} : '0);
    div_diff = acc_reg[2*WIDTH-1:WIDTH-1] - {1'b0, b_mag_reg};
    if (!op_reg[1])
      acc_step = {mul_sum, acc_reg[WIDTH-1:1]};
    else if (!div_diff[WIDTH])
      acc_step = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    else
      acc_step = {acc_reg[2*WIDTH-2:0], 1'b0};
  end

  // -2^31 / -1 needs no special path: magnitudes 0x8000_0000/1 give quotient 0x8000_0000, remainder 0
  always_comb begin
    prod_fix = (sa_reg ^ sb_reg) ? -acc_reg : acc_reg;
    quo      = acc_reg[WIDTH-1:0];
    rem      = acc_reg[2*WIDTH-1:WIDTH];
    b_zero   = (b_mag_reg == '0);
    case (op_reg)
      2'b00:   result = prod_fix[WIDTH-1:0];
      2'b01:   result = prod_fix[2*WIDTH-1:WIDTH];
      2'b10:   result = b_zero ? '1 : ((sa_reg ^ sb_reg) ? -quo : quo);
      default: result = b_zero ? a_raw_reg : (sa_reg ? -rem : rem);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      a_mag_reg <= '0;
      b_mag_reg <= '0;
      a_raw_reg <= '0;
      sa_reg    <= 1'b0;
      sb_reg    <= 1'b0;
      op_reg    <= 2'b00;
      rd_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      we_reg    <= 1'b0;
      wa_reg    <= '0;
      wd_reg    <= '0;
    end else begin
      we_reg   <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        // WB returns to IDLE on its closing edge, so a start there is accepted back-to-back
        IDLE, WB: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
          if (start) begin
            busy_reg  <= 1'b1;
            state_reg <= CALC;
            cnt_reg   <= '0;
            a_mag_reg <= a_mag_in;
            b_mag_reg <= b_mag_in;
            a_raw_reg <= RD1;
            sa_reg    <= sa_in;
            sb_reg    <= sb_in;
            op_reg    <= op;
            rd_reg    <= rd_addr;
            acc_reg   <= {{WIDTH{1'b0}}, (op[1] ? a_mag_in : b_mag_in)};
          end
        end
        CALC: begin
          acc_reg <= acc_step;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1))
            state_reg <= FIX;
        end
        FIX: begin
          wd_reg    <= result;
          wa_reg    <= rd_reg;
          we_reg    <= (rd_reg != '0);
          done_reg  <= 1'b1;
          state_reg <= WB;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign WE   = we_reg;
  assign WA   = wa_reg;
  assign WD   = wd_reg;
endmodule

// File: tb/tb_rf_muldiv_unit.sv
// Scoreboard bench for rf_muldiv_unit with a behavioural reg_file capturing the write port.
module tb_rf_muldiv_unit;
  localparam int WIDTH = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic             sgn;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] RD1, RD2;
  logic             busy, done, WE;
  logic [AW-1:0]    WA;
  logic [WIDTH-1:0] WD;

  typedef struct packed {
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] data;
    logic             we;
  } exp_t;

  exp_t             sb_q[$];
  int               tests = 0;
  int               fails = 0;
  int               exp_writes = 0;
  int               we_count = 0;
  logic [WIDTH-1:0] regs [32] = '{default: '0};

  rf_muldiv_unit #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sgn(sgn), .rd_addr(rd_addr),
    .RD1(RD1), .RD2(RD2), .busy(busy), .done(done), .WA(WA), .WD(WD), .WE(WE)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (WE === 1'b1) begin
      if (WA != '0) regs[WA] <= WD;
      we_count <= we_count + 1;
    end
  end

  // Drive one request at a negedge; it is accepted at the following posedge.
  task automatic issue(input logic [1:0] o, input logic s, input logic [AW-1:0] rd,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] exp_d);
    start = 1'b1; op = o; sgn = s; rd_addr = rd; RD1 = a; RD2 = b;
    sb_q.push_back('{rd: rd, data: exp_d, we: (rd != '0)});
    @(negedge clk);
    start = 1'b0;
    RD1 = $urandom;
    RD2 = $urandom;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_after_accept: busy=%b required 1", busy);
    end
  endtask

  // Scoreboard monitor: waits for done, pops the expected write and compares.
  task automatic wait_done(input int inj_cycle, input logic [AW-1:0] inj_rd);
    int   c;
    exp_t e;
    c = 1;
    while (done !== 1'b1 && c < 100) begin
      if (c == inj_cycle) begin
        start = 1'b1;
        rd_addr = inj_rd;
      end
      @(negedge clk);
      start = 1'b0;
      c++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL wb_timeout: done=%b after %0d cycles, required 1", done, c);
    end else begin
      tests++;
      if (c != WIDTH + 2) begin
        fails++;
        $display("FAIL wb_latency: %0d edges, required %0d", c, WIDTH + 2);
      end
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_empty: unexpected done with WA=%0d WD=%h", WA, WD);
      end else begin
        e = sb_q.pop_front();
        tests++;
        if (WA !== e.rd) begin
          fails++;
          $display("FAIL wb_wa: WA=%0d required %0d", WA, e.rd);
        end
        tests++;
        if (WD !== e.data) begin
          fails++;
          $display("FAIL wb_wd: WD=%h required %h", WD, e.data);
        end
        tests++;
        if (WE !== e.we) begin
          fails++;
          $display("FAIL wb_we: WE=%b required %b", WE, e.we);
        end
        if (e.we) exp_writes++;
        $display("[TB] wb rd=%0d WD=%h WE=%b latency=%0d", WA, WD, WE, c);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; sgn = 1'b0; rd_addr = '0; RD1 = '0; RD2 = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, WE} !== 3'b000 || WA !== '0 || WD !== '0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b WE=%b WA=%0d WD=%h required all 0",
               busy, done, WE, WA, WD);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_busy: busy=%b required 0", busy);
    end
  endtask

  task automatic test_mul();
    logic [WIDTH-1:0]   a, b;
    logic [2*WIDTH-1:0] p;
    issue(2'b00, 1'b0, 5'd3, 32'd7, 32'd6, 32'd42);
    wait_done(0, '0);
    @(negedge clk);
    tests++;
    if (regs[3] !== 32'd42) begin
      fails++;
      $display("FAIL mul_regfile_r3: r3=%h required 0000002a", regs[3]);
    end
    tests++;
    if ({busy, done, WE} !== 3'b000) begin
      fails++;
      $display("FAIL mul_idle_after_wb: busy=%b done=%b WE=%b required 000", busy, done, WE);
    end
    issue(2'b01, 1'b1, 5'd4, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    wait_done(0, '0);
    issue(2'b00, 1'b1, 5'd5, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    wait_done(0, '0);
    issue(2'b01, 1'b1, 5'd6, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF);
    wait_done(0, '0);
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    p = {32'd0, a} * {32'd0, b};
    issue(2'b01, 1'b0, 5'd7, a, b, p[2*WIDTH-1:WIDTH]);
    wait_done(0, '0);
    issue(2'b00, 1'b0, 5'd8, a, b, p[WIDTH-1:0]);
    wait_done(0, '0);
  endtask

  task automatic test_div();
    issue(2'b10, 1'b1, 5'd10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    wait_done(0, '0);
    issue(2'b11, 1'b1, 5'd11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    wait_done(0, '0);
    issue(2'b10, 1'b0, 5'd12, 32'd100, 32'd7, 32'd14);
    wait_done(0, '0);
    issue(2'b11, 1'b0, 5'd13, 32'd100, 32'd7, 32'd2);
    wait_done(0, '0);
    issue(2'b11, 1'b1, 5'd14, 32'd7, 32'hFFFF_FFFE, 32'd1);
    wait_done(0, '0);
  endtask

  task automatic test_div_special();
    issue(2'b10, 1'b0, 5'd15, 32'd5, 32'd0, 32'hFFFF_FFFF);
    wait_done(0, '0);
    issue(2'b11, 1'b0, 5'd16, 32'd5, 32'd0, 32'd5);
    wait_done(0, '0);
    issue(2'b11, 1'b1, 5'd17, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    wait_done(0, '0);
    issue(2'b10, 1'b1, 5'd18, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    wait_done(0, '0);
    issue(2'b10, 1'b1, 5'd19, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    wait_done(0, '0);
    issue(2'b11, 1'b1, 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    wait_done(0, '0);
  endtask

  task automatic test_handshake();
    int extra_done;
    @(negedge clk);
    issue(2'b00, 1'b0, 5'd21, 32'd3, 32'd3, 32'd9);
    wait_done(5, 5'd22);
    extra_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
    end
    tests++;
    if (extra_done != 0 || regs[22] !== '0) begin
      fails++;
      $display("FAIL ignored_start: extra_done=%0d r22=%h required 0 and 0", extra_done, regs[22]);
    end
    tests++;
    if (we_count != exp_writes) begin
      fails++;
      $display("FAIL write_count: %0d WE pulses, required %0d", we_count, exp_writes);
    end
    issue(2'b00, 1'b0, 5'd0, 32'd5, 32'd5, 32'd25);
    wait_done(0, '0);
    @(negedge clk);
    tests++;
    if (we_count != exp_writes || regs[0] !== '0) begin
      fails++;
      $display("FAIL r0_protect: WE pulses=%0d r0=%h required %0d and 0", we_count, regs[0], exp_writes);
    end
  endtask

  task automatic test_back_to_back();
    issue(2'b00, 1'b0, 5'd23, 32'd11, 32'd13, 32'd143);
    wait_done(0, '0);
    issue(2'b10, 1'b0, 5'd24, 32'd143, 32'd11, 32'd13);
    wait_done(0, '0);
    @(negedge clk);
    tests++;
    if (regs[23] !== 32'd143 || regs[24] !== 32'd13) begin
      fails++;
      $display("FAIL back_to_back_regs: r23=%h r24=%h required 0000008f 0000000d", regs[23], regs[24]);
    end
  endtask

  task automatic test_reset_midop();
    issue(2'b00, 1'b0, 5'd9, 32'd11, 32'd11, 32'd121);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, WE} !== 3'b000 || WA !== '0 || WD !== '0) begin
      fails++;
      $display("FAIL reset_midop: busy=%b done=%b WE=%b WA=%0d WD=%h required all 0",
               busy, done, WE, WA, WD);
    end
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    tests++;
    if (regs[9] !== '0 || we_count != exp_writes) begin
      fails++;
      $display("FAIL reset_no_write: r9=%h WE pulses=%0d required 0 and %0d", regs[9], we_count, exp_writes);
    end
    issue(2'b00, 1'b0, 5'd9, 32'd11, 32'd11, 32'd121);
    wait_done(0, '0);
    @(negedge clk);
    tests++;
    if (regs[9] !== 32'd121) begin
      fails++;
      $display("FAIL reset_recover: r9=%h required 00000079", regs[9]);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_handshake();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
